// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency memory port between the IFU (reads) and the EXE
//   unit (reads and writes). Exactly one transaction is in flight at a time.
//   Fixed priority in IDLE: exe_wr_req > exe_rd_req > ifu_rd_req.
//
//   Optional build macro: ARB_STARVE_GUARD_EN
//     When defined, a saturating counter tracks cycles in which the IFU is
//     requesting but not being served. Once it reaches STARVE_LIMIT, the IFU
//     wins the next IDLE arbitration over both EXE requests.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   ifu_rd_req/addr -> data/ack IFU read channel (level req, 1-cycle ack)
//   exe_rd_req/addr -> data/ack EXE read channel
//   exe_wr_req/addr/data -> ack EXE write channel
//   mem_rd_req, mem_wr_req      1-cycle memory strobes
//   mem_addr, mem_wr_data       registered memory address / write data
//   mem_rd_data                 read data, valid MEM_RD_LAT cycles after strobe
//   busy                        high whenever the FSM is not in IDLE
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 12,
    parameter int MEM_RD_LAT   = 1,   // legal 1..7
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_ack,
    input  logic                  exe_rd_req,
    input  logic [ADDR_WIDTH-1:0] exe_rd_addr,
    output logic [DATA_WIDTH-1:0] exe_rd_data,
    output logic                  exe_rd_ack,
    input  logic                  exe_wr_req,
    input  logic [ADDR_WIDTH-1:0] exe_wr_addr,
    input  logic [DATA_WIDTH-1:0] exe_wr_data,
    output logic                  exe_wr_ack,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, ISSUE_RD, RD_WAIT, RESP, ISSUE_WR} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_EXE_RD, OWN_EXE_WR} owner_t;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_RD_LAT - 1);

    state_t                state, state_nx;
    owner_t                owner, owner_nx;
    logic [2:0]            wait_cnt, wait_cnt_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx, ifu_data_nx, exe_data_nx;
    logic                  rd_strobe_nx, wr_strobe_nx;
    logic                  ifu_ack_nx, exe_rd_ack_nx, exe_wr_ack_nx, busy_nx;
    logic                  ifu_grant, starve_win, ack_out;

    // A read ack is presented while the FSM already sits in IDLE. The requester
    // only drops req on the edge that samples the ack, so arbitration is held
    // off during that cycle to avoid serving the same request twice.
    assign ack_out = ifu_rd_ack | exe_rd_ack | exe_wr_ack;

`ifdef ARB_STARVE_GUARD_EN
    localparam int              SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_cnt;
    logic            ifu_waiting;

    // The IFU's own transaction, including its ack cycle, is not waiting time.
    assign ifu_waiting = ifu_rd_req &&
                         !(owner == OWN_IFU && (state != IDLE || ifu_rd_ack));
    assign starve_win  = ifu_rd_req && (starve_cnt >= SC_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= '0;
        else if (ifu_grant)
            starve_cnt <= '0;
        else if (ifu_waiting && starve_cnt != SC_LIM)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign starve_win = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        wait_cnt_nx   = wait_cnt;
        addr_nx       = mem_addr;
        wdata_nx      = mem_wr_data;
        ifu_data_nx   = ifu_rd_data;
        exe_data_nx   = exe_rd_data;
        rd_strobe_nx  = 1'b0;
        wr_strobe_nx  = 1'b0;
        ifu_ack_nx    = 1'b0;
        exe_rd_ack_nx = 1'b0;
        exe_wr_ack_nx = 1'b0;
        ifu_grant     = 1'b0;

        case (state)
            IDLE: begin
                if (!ack_out) begin
                    if (starve_win || (ifu_rd_req && !exe_wr_req && !exe_rd_req)) begin
                        ifu_grant    = 1'b1;
                        owner_nx     = OWN_IFU;
                        addr_nx      = ifu_rd_addr;
                        rd_strobe_nx = 1'b1;
                        state_nx     = ISSUE_RD;
                    end else if (exe_wr_req) begin
                        owner_nx      = OWN_EXE_WR;
                        addr_nx       = exe_wr_addr;
                        wdata_nx      = exe_wr_data;
                        wr_strobe_nx  = 1'b1;
                        exe_wr_ack_nx = 1'b1;  // write ack rides with the strobe
                        state_nx      = ISSUE_WR;
                    end else if (exe_rd_req) begin
                        owner_nx     = OWN_EXE_RD;
                        addr_nx      = exe_rd_addr;
                        rd_strobe_nx = 1'b1;
                        state_nx     = ISSUE_RD;
                    end
                end
            end
            ISSUE_RD: begin
                wait_cnt_nx = WAIT_LOAD;
                state_nx    = (MEM_RD_LAT == 1) ? RESP : RD_WAIT;
            end
            RD_WAIT: begin
                wait_cnt_nx = wait_cnt - 1'b1;
                if (wait_cnt == 3'd1)
                    state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
                if (owner == OWN_IFU) begin
                    ifu_data_nx = mem_rd_data;
                    ifu_ack_nx  = 1'b1;
                end else begin
                    exe_data_nx   = mem_rd_data;
                    exe_rd_ack_nx = 1'b1;
                end
            end
            ISSUE_WR: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            wait_cnt    <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            ifu_rd_data <= '0;
            exe_rd_data <= '0;
            ifu_rd_ack  <= 1'b0;
            exe_rd_ack  <= 1'b0;
            exe_wr_ack  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            wait_cnt    <= wait_cnt_nx;
            mem_addr    <= addr_nx;
            mem_wr_data <= wdata_nx;
            mem_rd_req  <= rd_strobe_nx;
            mem_wr_req  <= wr_strobe_nx;
            ifu_rd_data <= ifu_data_nx;
            exe_rd_data <= exe_data_nx;
            ifu_rd_ack  <= ifu_ack_nx;
            exe_rd_ack  <= exe_rd_ack_nx;
            exe_wr_ack  <= exe_wr_ack_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. u_dut runs MEM_RD_LAT=1 with full
// stimulus; u_dut3 runs MEM_RD_LAT=3 with IFU reads only. Both share one
// memory model that is re-initialised whenever reset is high.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_rd_req = 1'b0, exe_rd_req = 1'b0, exe_wr_req = 1'b0;
    logic [11:0] ifu_rd_addr = '0, exe_rd_addr = '0, exe_wr_addr = '0, exe_wr_data = '0;
    logic [11:0] ifu_rd_data, exe_rd_data, mem_addr, mem_wr_data, rd1;
    logic        ifu_rd_ack, exe_rd_ack, exe_wr_ack, mem_rd_req, mem_wr_req, busy;

    logic        ifu_req3 = 1'b0;
    logic [11:0] ifu_addr3 = '0;
    logic [11:0] ifu_rd_data3, exe_rd_data3, mem_addr3, mem_wr_data3;
    logic        ifu_rd_ack3, exe_rd_ack3, exe_wr_ack3, mem_rd_req3, mem_wr_req3, busy3;

    logic [11:0] mem [0:4095];
    logic [11:0] p3 [0:2];

    int n_chk = 0, n_err = 0;
    int ifu_acks = 0, exe_rd_acks = 0, exe_wr_acks = 0, ifu_acks3 = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MEM_RD_LAT(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data), .ifu_rd_ack(ifu_rd_ack),
        .exe_rd_req(exe_rd_req), .exe_rd_addr(exe_rd_addr), .exe_rd_data(exe_rd_data), .exe_rd_ack(exe_rd_ack),
        .exe_wr_req(exe_wr_req), .exe_wr_addr(exe_wr_addr), .exe_wr_data(exe_wr_data), .exe_wr_ack(exe_wr_ack),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(rd1), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MEM_RD_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .ifu_rd_req(ifu_req3), .ifu_rd_addr(ifu_addr3), .ifu_rd_data(ifu_rd_data3), .ifu_rd_ack(ifu_rd_ack3),
        .exe_rd_req(1'b0), .exe_rd_addr(12'd0), .exe_rd_data(exe_rd_data3), .exe_rd_ack(exe_rd_ack3),
        .exe_wr_req(1'b0), .exe_wr_addr(12'd0), .exe_wr_data(12'd0), .exe_wr_ack(exe_wr_ack3),
        .mem_rd_req(mem_rd_req3), .mem_wr_req(mem_wr_req3), .mem_addr(mem_addr3), .mem_wr_data(mem_wr_data3),
        .mem_rd_data(p3[2]), .busy(busy3)
    );

    // Memory model: 1-cycle registered read for u_dut, 3-stage pipe for u_dut3.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 12'(i * 5 + 3);
            mem[12'o200] <= 12'o7001;
            mem[12'o050] <= 12'o0123;
        end else if (mem_wr_req) begin
            mem[mem_addr] <= mem_wr_data;
        end
        if (mem_rd_req) rd1 <= mem[mem_addr];
        p3[0] <= mem[mem_addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    always @(posedge clk) begin
        ifu_acks    <= ifu_acks    + int'(ifu_rd_ack);
        exe_rd_acks <= exe_rd_acks + int'(exe_rd_ack);
        exe_wr_acks <= exe_wr_acks + int'(exe_wr_ack);
        ifu_acks3   <= ifu_acks3   + int'(ifu_rd_ack3);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_of(input int which);
        case (which)
            0:       return ifu_rd_ack;
            1:       return exe_rd_ack;
            2:       return exe_wr_ack;
            default: return ifu_rd_ack3;
        endcase
    endfunction

    // Called just after the sampling edge. Returns the request-to-ack latency
    // as seen by the requester (ack is sampled on the edge after it appears),
    // or -1 on timeout, plus the number of memory strobes seen while waiting.
    task automatic wait_ack(input int which, input int budget, output int lat, output int strobes);
        lat = -1;
        strobes = 0;
        for (int n = 1; n <= budget; n++) begin
            tick();
            strobes += (which == 3) ? int'(mem_rd_req3 | mem_wr_req3) : int'(mem_rd_req | mem_wr_req);
            if (ack_of(which)) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    initial begin
        int lat, strb, t_a, t_b, a0, b0, c0, exe_n, exe_before;
        logic [11:0] d_a, d_b;

        // Reset state
        repeat (2) tick();
        chk("reset_outs", {ifu_rd_data, ifu_rd_ack, exe_rd_data, exe_rd_ack, exe_wr_ack,
                           mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, busy}, 64'd0);
        reset = 1'b0;
        tick();

        // 1: single IFU read, MEM_RD_LAT=1
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        tick();
        chk("t1_strobe", {mem_rd_req, mem_wr_req}, 2'b10);
        chk("t1_addr", mem_addr, 12'o200);
        chk("t1_busy", busy, 1'b1);
        wait_ack(0, 10, lat, strb);
        ifu_rd_req = 1'b0;
        chk("t1_lat", lat, 3);
        chk("t1_strobe_once", strb, 0);
        chk("t1_data", ifu_rd_data, 12'o7001);
        tick();
        chk("t1_after", {busy, ifu_rd_ack, mem_rd_req}, 3'b000);

        // 2: IFU and EXE reads together -> EXE first, then IFU, one ack each
        a0 = ifu_acks; b0 = exe_rd_acks; t_a = -1; t_b = -1; d_a = '0; d_b = '0;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        exe_rd_req = 1'b1; exe_rd_addr = 12'o050;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) chk("t2_first_addr", mem_addr, 12'o050);
            if (exe_rd_ack) begin exe_rd_req = 1'b0; t_b = i; d_b = exe_rd_data; end
            if (ifu_rd_ack) begin ifu_rd_req = 1'b0; t_a = i; d_a = ifu_rd_data; end
        end
        chk("t2_exe_t", t_b, 3);
        chk("t2_ifu_t", t_a, 7);
        chk("t2_exe_data", d_b, 12'o0123);
        chk("t2_ifu_data", d_a, 12'o7001);
        chk("t2_ack_cnt", {32'(ifu_acks - a0), 32'(exe_rd_acks - b0)}, {32'd1, 32'd1});

        // 3: EXE write and read together -> write first, read sees new data
        c0 = exe_wr_acks; t_a = -1; t_b = -1; d_b = '0;
        exe_wr_req = 1'b1; exe_wr_addr = 12'o050; exe_wr_data = 12'o1234;
        exe_rd_req = 1'b1; exe_rd_addr = 12'o050;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) begin
                chk("t3_wr_strobe", {mem_wr_req, mem_rd_req, mem_addr, mem_wr_data}, {2'b10, 12'o050, 12'o1234});
                exe_wr_data = 12'o7777;  // must be ignored, value latched at grant
            end
            if (exe_wr_ack) begin exe_wr_req = 1'b0; t_a = i; end
            if (exe_rd_ack) begin exe_rd_req = 1'b0; t_b = i; d_b = exe_rd_data; end
        end
        chk("t3_wr_t", t_a, 1);
        chk("t3_rd_t", t_b, 5);
        chk("t3_rd_data", d_b, 12'o1234);
        chk("t3_wr_cnt", exe_wr_acks - c0, 1);

        // 4: MEM_RD_LAT=3 instance
        ifu_req3 = 1'b1; ifu_addr3 = 12'o200;
        tick();
        chk("t4_strobe", {mem_rd_req3, mem_addr3}, {1'b1, 12'o200});
        wait_ack(3, 12, lat, strb);
        ifu_req3 = 1'b0;
        chk("t4_lat", lat, 5);
        chk("t4_no_strobe_wait", strb, 0);
        chk("t4_data", ifu_rd_data3, 12'o7001);

        // 5: reset in RD_WAIT
        tick();
        ifu_req3 = 1'b1; ifu_addr3 = 12'o200;
        tick();
        tick();
        chk("t5_in_wait", {busy3, mem_rd_req3}, 2'b10);
        #2 reset = 1'b1; ifu_req3 = 1'b0;
        #1;
        chk("t5_async_clr", {busy3, mem_rd_req3, mem_addr3, ifu_rd_data3, ifu_rd_ack3}, 64'd0);
        tick();
        reset = 1'b0;
        a0 = ifu_acks3;
        repeat (6) tick();
        chk("t5_no_ack", ifu_acks3 - a0, 0);
        ifu_req3 = 1'b1; ifu_addr3 = 12'o200;
        tick();
        wait_ack(3, 12, lat, strb);
        ifu_req3 = 1'b0;
        chk("t5_new_lat", lat, 5);
        chk("t5_new_data", ifu_rd_data3, 12'o7001);

        // 6: EXE back-to-back reads with IFU waiting
        tick();
        exe_n = 0; exe_before = -1;
        exe_rd_req = 1'b1; exe_rd_addr = 12'o050;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (exe_rd_ack) begin
                exe_n++;
                if (exe_n >= 3) exe_rd_req = 1'b0;
            end
            if (ifu_rd_ack) begin
                ifu_rd_req = 1'b0;
                exe_before = exe_n;
                break;
            end
        end
        exe_rd_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        chk("t6_exe_before_ifu", exe_before, 1);
`else
        chk("t6_exe_before_ifu", exe_before, 3);
`endif
        repeat (4) tick();
        chk("t6_idle", busy, 1'b0);

        // u_dut3 never sees EXE traffic
        chk("dut3_exe_quiet", {exe_rd_data3, exe_rd_ack3, exe_wr_ack3, mem_wr_req3, mem_wr_data3}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
